// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter. Grants round-robin under contention, inserts
// per-target wait states, and drives the shared data bus only during write ACCESS.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_WAIT   = 0,
    parameter int ROM_WAIT   = 1,
    parameter int PERIF_WAIT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [1:0]            m0_cs,
    input  logic                  m0_we,
    input  logic [1:0]            m0_size,
    input  logic [63:0]           m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [63:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [1:0]            m1_cs,
    input  logic                  m1_we,
    input  logic [1:0]            m1_size,
    input  logic [63:0]           m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [63:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_cs,
    output logic                  mem_write_en,
    output logic                  mem_read,
    output logic [1:0]            size,
    inout  wire  [63:0]           mem_data,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    // Handshake: a master raises mN_req with stable addr/cs/we/size/wdata and holds
    // it until mN_ack is sampled high; only the grant edge samples those inputs.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic                  last;
    logic                  owner;
    logic [3:0]            wait_cnt;
    logic [63:0]           wdata_q;

    logic                  pick1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_cs;
    logic                  sel_we;
    logic [1:0]            sel_size;
    logic [63:0]           sel_wdata;
    logic [3:0]            sel_wait;

    always_comb begin
        pick1     = (m0_req && m1_req) ? ~last : m1_req;
        sel_addr  = pick1 ? m1_addr  : m0_addr;
        sel_cs    = pick1 ? m1_cs    : m0_cs;
        sel_we    = pick1 ? m1_we    : m0_we;
        sel_size  = pick1 ? m1_size  : m0_size;
        sel_wdata = pick1 ? m1_wdata : m0_wdata;
        case (sel_cs)
            2'b01:   sel_wait = 4'(RAM_WAIT);
            2'b10:   sel_wait = 4'(ROM_WAIT);
            default: sel_wait = 4'(PERIF_WAIT);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            wait_cnt     <= 4'd0;
            wdata_q      <= 64'd0;
            grant        <= 2'b00;
            m0_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m0_rdata     <= 64'd0;
            m1_ack       <= 1'b0;
            m1_err       <= 1'b0;
            m1_rdata     <= 64'd0;
            mem_address  <= '0;
            mem_cs       <= 2'b00;
            size         <= 2'b00;
            mem_read     <= 1'b0;
            mem_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner <= pick1;
                        last  <= pick1;
                        grant <= pick1 ? 2'b10 : 2'b01;
                        if (sel_cs == 2'b00) begin
                            // Unused target: answer with an error, never touch the bus.
                            state <= DONE;
                            if (pick1) begin
                                m1_ack   <= 1'b1;
                                m1_err   <= 1'b1;
                                m1_rdata <= 64'd0;
                            end else begin
                                m0_ack   <= 1'b1;
                                m0_err   <= 1'b1;
                                m0_rdata <= 64'd0;
                            end
                        end else begin
                            state        <= ACCESS;
                            wait_cnt     <= sel_wait;
                            mem_address  <= sel_addr;
                            mem_cs       <= sel_cs;
                            size         <= sel_size;
                            mem_write_en <= sel_we;
                            mem_read     <= ~sel_we;
                            wdata_q      <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (mem_read) begin
                            if (owner) m1_rdata <= mem_data;
                            else       m0_rdata <= mem_data;
                        end
                        if (owner) m1_ack <= 1'b1;
                        else       m0_ack <= 1'b1;
                        mem_address  <= '0;
                        mem_cs       <= 2'b00;
                        size         <= 2'b00;
                        mem_read     <= 1'b0;
                        mem_write_en <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                    grant  <= 2'b00;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe doubles as the bus-drive enable, so reset releases the bus at once.
    assign mem_data  = mem_write_en ? wdata_q : 64'bz;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed and random transactions scored against a
// transaction-level model built from the arbitration and timing rules.
module tb_mem_bus_arbiter;

    localparam int AW      = 32;
    localparam int RAM_W   = 0;
    localparam int ROM_W   = 1;
    localparam int PERIF_W = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  cs;
        logic        we;
        logic [1:0]  sz;
        logic [63:0] wdata;
    } req_t;

    // clock / reset
    logic clock;
    logic reset;
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic          req_v [2];
    req_t          cur   [2];
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [63:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] mem_address;
    logic [1:0]    mem_cs, size, grant, fsm_state;
    logic          mem_write_en, mem_read, busy;
    wire  [63:0]   mem_data;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W), .PERIF_WAIT(PERIF_W)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_req(req_v[0]), .m0_addr(cur[0].addr), .m0_cs(cur[0].cs), .m0_we(cur[0].we),
        .m0_size(cur[0].sz), .m0_wdata(cur[0].wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req_v[1]), .m1_addr(cur[1].addr), .m1_cs(cur[1].cs), .m1_we(cur[1].we),
        .m1_size(cur[1].sz), .m1_wdata(cur[1].wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
        .mem_read(mem_read), .size(size), .mem_data(mem_data),
        .grant(grant), .busy(busy), .fsm_state(fsm_state)
    );

    // bus model: read data is a fixed function of the address
    function automatic logic [63:0] bus_val(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'h40;
        return 64'h0123456789ABCDEF ^ {d, d};
    endfunction

    assign mem_data = mem_read ? bus_val(mem_address) : 64'bz;

    function automatic int wait_of(input logic [1:0] cs);
        if (cs == 2'b01) return RAM_W;
        if (cs == 2'b10) return ROM_W;
        return PERIF_W;
    endfunction

    function automatic req_t rand_req(input logic [1:0] cs, input logic we);
        req_t r;
        r.addr  = $urandom;
        r.cs    = cs;
        r.we    = we;
        r.sz    = 2'($urandom_range(0, 3));
        r.wdata = {$urandom, $urandom};
        return r;
    endfunction

    // scoreboard state
    int          n_cmp, n_bad, cyc;
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    logic [63:0] model_rdata [2];
    req_t        plan0 [$];
    req_t        plan1 [$];
    int          gap [2];
    int          gap_max;
    req_t        tx;
    int          tx_owner, tx_t, tx_ack, next_free, last_m;
    bit          tx_err, tx_valid;
    bit          log_en;
    int          ack_cyc_q [$];
    int          ack_own_q [$];
    int          wr_cycles, rd_cycles, err_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_valid  = 1'b0;
        tx_err    = 1'b0;
        tx_owner  = 0;
        tx_t      = 0;
        tx_ack    = 0;
        tx        = '0;
        next_free = 0;
        last_m    = 1;
        exp_q0.delete();
        exp_q1.delete();
        plan0.delete();
        plan1.delete();
        for (int m = 0; m < 2; m++) begin
            model_rdata[m] = 64'd0;
            req_v[m]       = 1'b0;
            cur[m]         = '0;
            gap[m]         = 0;
        end
    endtask

    // One cycle: check outputs against the model, act as requesters, then arbitrate.
    task automatic cycle_body();
        bit          act, acc, ack_now;
        logic [63:0] e;
        int          w, win;
        act     = tx_valid && (cyc >= tx_t + 1) && (cyc <= tx_ack);
        acc     = act && !tx_err && (cyc < tx_ack);
        ack_now = tx_valid && (cyc == tx_ack);
        check("grant", 64'(grant), act ? ((tx_owner == 1) ? 64'd2 : 64'd1) : 64'd0);
        check("busy", 64'(busy), 64'(act));
        check("mem_read", 64'(mem_read), 64'(acc && !tx.we));
        check("mem_write_en", 64'(mem_write_en), 64'(acc && tx.we));
        check("mem_cs", 64'(mem_cs), acc ? 64'(tx.cs) : 64'd0);
        check("mem_address", 64'(mem_address), acc ? 64'(tx.addr) : 64'd0);
        check("size", 64'(size), acc ? 64'(tx.sz) : 64'd0);
        if (acc && tx.we) check("mem_data", mem_data, tx.wdata);
        check("m0_ack", 64'(m0_ack), 64'(ack_now && tx_owner == 0));
        check("m1_ack", 64'(m1_ack), 64'(ack_now && tx_owner == 1));
        check("m0_err", 64'(m0_err), 64'(ack_now && tx_owner == 0 && tx_err));
        check("m1_err", 64'(m1_err), 64'(ack_now && tx_owner == 1 && tx_err));
        if (ack_now) begin
            if (tx_owner == 0) e = exp_q0.pop_front();
            else               e = exp_q1.pop_front();
            model_rdata[tx_owner] = e;
        end
        check("m0_rdata", m0_rdata, model_rdata[0]);
        check("m1_rdata", m1_rdata, model_rdata[1]);
        if (log_en && m0_ack) begin ack_cyc_q.push_back(cyc); ack_own_q.push_back(0); end
        if (log_en && m1_ack) begin ack_cyc_q.push_back(cyc); ack_own_q.push_back(1); end
        if (mem_write_en) wr_cycles++;
        if (mem_read) rd_cycles++;
        if (m0_err) err_seen++;

        // requesters drop req on ack, then present the next planned access
        if (ack_now) begin
            req_v[tx_owner] = 1'b0;
            gap[tx_owner]   = $urandom_range(0, gap_max);
        end
        for (int m = 0; m < 2; m++) begin
            if (!req_v[m] && (((m == 0) ? plan0.size() : plan1.size()) != 0)) begin
                if (gap[m] > 0) begin
                    gap[m]--;
                end else begin
                    if (m == 0) cur[0] = plan0.pop_front();
                    else        cur[1] = plan1.pop_front();
                    req_v[m] = 1'b1;
                end
            end
        end

        // arbitration at the edge closing this cycle
        if (cyc >= next_free && (req_v[0] || req_v[1])) begin
            if (req_v[0] && req_v[1]) win = (last_m == 1) ? 0 : 1;
            else                      win = req_v[1] ? 1 : 0;
            last_m    = win;
            tx        = cur[win];
            tx_owner  = win;
            tx_t      = cyc;
            tx_valid  = 1'b1;
            tx_err    = (tx.cs == 2'b00);
            w         = wait_of(tx.cs);
            tx_ack    = tx_err ? cyc + 1 : cyc + 2 + w;
            next_free = tx_ack + 1;
            if (tx_err)      e = 64'd0;
            else if (!tx.we) e = bus_val(tx.addr);
            else             e = model_rdata[win];
            if (win == 0) exp_q0.push_back(e);
            else          exp_q1.push_back(e);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            cyc++;
            cycle_body();
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((plan0.size() != 0 || plan1.size() != 0 || req_v[0] || req_v[1] ||
                (tx_valid && cyc < tx_ack)) && n < max_cyc) begin
            run_cycles(1);
            n++;
        end
        check("drain_done", 64'(n < max_cyc), 64'd1);
        run_cycles(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        gap_max = 0; log_en = 1'b0;
        wr_cycles = 0; rd_cycles = 0; err_seen = 0;
        reset = 1'b0;
        model_reset();
        #7;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_m0_ack", 64'(m0_ack), 64'd0);
        check("rst_m1_ack", 64'(m1_ack), 64'd0);
        check("rst_m0_err", 64'(m0_err), 64'd0);
        check("rst_m1_err", 64'(m1_err), 64'd0);
        check("rst_m0_rdata", m0_rdata, 64'd0);
        check("rst_m1_rdata", m1_rdata, 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_mem_cs", 64'(mem_cs), 64'd0);
        check("rst_size", 64'(size), 64'd0);
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_write_en", 64'(mem_write_en), 64'd0);

        // contention from reset release: 8 ROM reads, both req held high
        for (int i = 0; i < 4; i++) begin
            plan0.push_back(rand_req(2'b10, 1'b0));
            plan1.push_back(rand_req(2'b10, 1'b0));
        end
        @(negedge clock);
        reset = 1'b1;
        cyc++;
        log_en = 1'b1;
        cycle_body();
        run_cycles(1);
        check("c_first_grant", 64'(grant), 64'd1);
        drain(200);
        log_en = 1'b0;
        check("c_ack_count", 64'(ack_cyc_q.size()), 64'd8);
        for (int i = 0; i < ack_cyc_q.size(); i++) begin
            check("c_ack_owner", 64'(ack_own_q[i]), 64'(i % 2));
            if (i > 0) check("c_ack_spacing", 64'(ack_cyc_q[i] - ack_cyc_q[i-1]), 64'd4);
        end

        // m0 read from RAM
        plan0.push_back('{addr: 32'h0000_0040, cs: 2'b01, we: 1'b0, sz: 2'b11, wdata: 64'd0});
        drain(50);
        check("a_rdata", m0_rdata, 64'h0123456789ABCDEF);

        // m1 write to peripheral
        wr_cycles = 0;
        plan1.push_back('{addr: 32'h0000_FF00, cs: 2'b11, we: 1'b1, sz: 2'b10,
                          wdata: 64'hDEADBEEFCAFEF00D});
        drain(50);
        check("b_write_cycles", 64'(wr_cycles), 64'd3);

        // m0 access to the unused target
        wr_cycles = 0; rd_cycles = 0; err_seen = 0;
        plan0.push_back(rand_req(2'b00, 1'($urandom_range(0, 1))));
        drain(50);
        check("d_no_strobe", 64'(wr_cycles + rd_cycles), 64'd0);
        check("d_err_seen", 64'(err_seen), 64'd1);
        check("d_rdata", m0_rdata, 64'd0);

        // random traffic from both masters
        gap_max = 3;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0)
                plan0.push_back(rand_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
            else
                plan1.push_back(rand_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
            run_cycles($urandom_range(0, 4));
        end
        drain(3000);
        gap_max = 0;

        // reset in the middle of an m1 peripheral write
        plan1.push_back(rand_req(2'b11, 1'b1));
        run_cycles(2);
        #1;
        reset = 1'b0;
        #1;
        check("f_write_en_async", 64'(mem_write_en), 64'd0);
        check("f_mem_cs_async", 64'(mem_cs), 64'd0);
        check("f_grant_async", 64'(grant), 64'd0);
        check("f_busy_async", 64'(busy), 64'd0);
        model_reset();
        repeat (2) begin
            @(negedge clock);
            check("f_no_ack", 64'(m1_ack), 64'd0);
            check("f_no_write", 64'(mem_write_en), 64'd0);
        end
        plan0.push_back(rand_req(2'b10, 1'b0));
        plan1.push_back(rand_req(2'b10, 1'b0));
        @(negedge clock);
        reset = 1'b1;
        cyc++;
        cycle_body();
        run_cycles(1);
        check("f_first_grant", 64'(grant), 64'd1);
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
